alu_arbiter: RTL and testbench

Shares the single 32-bit combinational ALU between two requesters, such as the execute-stage sequencer and the address/branch unit. It accepts one operation at a time over valid/ready request channels and arbitrates between the two requesters. It drives the ALU from registered operands and returns the registered result and zero flag on a per-requester response channel. It sits directly in front of the ALU and is the ALU's only driver.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 32-bit ALU: valid/ready request channels,
// one op in flight, registered operands and result. Build macro: ALU_ARB_RR_EN (round-robin).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_first_operand,
  output logic [DATA_W-1:0] alu_second_operand,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q;
  logic              owner_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [3:0]        ctrl_q;
  logic              zero_q;

  logic              grant1;
  logic              hs0, hs1;
  logic [DATA_W-1:0] a_d, b_d;
  logic [3:0]        ctrl_d;
  logic              rsp_take;

`ifdef ALU_ARB_RR_EN
  logic last_grant_q;
  // req1 wins a tie only when req0 was served last.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
`else
  assign grant1 = req1_valid & ~req0_valid;
`endif

  assign hs0 = (state_q == IDLE) & req0_valid & ~grant1;
  assign hs1 = (state_q == IDLE) & grant1;

  // Readys are forced low while reset is held, without pulling rst_n into any flop's data path.
  assign req0_ready = hs0 & rst_n;
  assign req1_ready = hs1 & rst_n;

  assign a_d    = hs1 ? req1_a    : req0_a;
  assign b_d    = hs1 ? req1_b    : req0_b;
  assign ctrl_d = hs1 ? req1_ctrl : req0_ctrl;

  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;

  assign rsp0_valid  = (state_q == RESP) & ~owner_q;
  assign rsp1_valid  = (state_q == RESP) &  owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

  assign alu_first_operand  = a_q;
  assign alu_second_operand = b_q;
  assign alu_control        = ctrl_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 4'b0010;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs0 | hs1) begin
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            owner_q <= hs1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_take) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == RESP && rsp_take) begin
      last_grant_q <= owner_q;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against
// a cycle-timeline reference model; includes a behavioural ALU that answers the DUT.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [3:0]  req_ctrl [2];
  logic [1:0]  rsp_ready;
  wire         req0_ready, req1_ready;
  wire  [1:0]  rsp_valid;
  wire  [31:0] rsp_result [2];
  wire  [1:0]  rsp_zero;
  wire  [31:0] alu_first_operand, alu_second_operand;
  wire  [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req0_ready),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_ctrl(req_ctrl[0]),
    .req1_valid(req_valid[1]), .req1_ready(req1_ready),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_ctrl(req_ctrl[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_result(rsp_result[0]), .rsp0_zero(rsp_zero[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_result(rsp_result[1]), .rsp1_zero(rsp_zero[1]),
    .alu_first_operand(alu_first_operand), .alu_second_operand(alu_second_operand),
    .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_first_operand, alu_second_operand, alu_control);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: at most one op in flight, response visible from handshake cycle + 2.
  bit          m_busy, m_owner, m_last;
  int          m_hs;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_c;
  int          hs_cnt [2];
  bit          grant_log [$];

  initial begin
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;
  end

  always @(negedge clk or negedge rst_n) begin
    logic [1:0] exp_rdy, exp_rv;
    bit g;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      exp_rdy = 2'b00;
      g = req_valid[1];
      if (!m_busy && req_valid != 2'b00) begin
        if (req_valid == 2'b11) g = RR_EN ? ~m_last : 1'b0;
        exp_rdy[g] = 1'b1;
      end
      check("ready0", {31'd0, req0_ready}, {31'd0, exp_rdy[0]});
      check("ready1", {31'd0, req1_ready}, {31'd0, exp_rdy[1]});
      exp_rv = 2'b00;
      if (m_busy && cyc >= m_hs + 2) exp_rv[m_owner] = 1'b1;
      check("rsp0_valid", {31'd0, rsp_valid[0]}, {31'd0, exp_rv[0]});
      check("rsp1_valid", {31'd0, rsp_valid[1]}, {31'd0, exp_rv[1]});
      if (m_busy && cyc == m_hs + 1) begin
        check("alu_a", alu_first_operand, m_a);
        check("alu_b", alu_second_operand, m_b);
        check("alu_ctrl", {28'd0, alu_control}, {28'd0, m_c});
      end
      if (exp_rv != 2'b00) begin
        check("rsp_result", rsp_result[m_owner], m_res);
        check("rsp_zero", {31'd0, rsp_zero[m_owner]}, {31'd0, m_res == 32'd0});
      end
      if (exp_rv != 2'b00 && rsp_ready[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (exp_rdy != 2'b00) begin
        m_busy  = 1'b1;
        m_owner = g;
        m_hs    = cyc;
        m_a     = req_a[g];
        m_b     = req_b[g];
        m_c     = req_ctrl[g];
        m_res   = alu_f(m_a, m_b, m_c);
        hs_cnt[g] = hs_cnt[g] + 1;
        grant_log.push_back(g);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check({tag, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    check({tag, "_result0"}, rsp_result[0], 32'd0);
    check({tag, "_result1"}, rsp_result[1], 32'd0);
    check({tag, "_zero"}, {30'd0, rsp_zero}, 32'd0);
    check({tag, "_alu_a"}, alu_first_operand, 32'd0);
    check({tag, "_alu_b"}, alu_second_operand, 32'd0);
    check({tag, "_alu_ctrl"}, {28'd0, alu_control}, 32'd2);
  endtask

  task automatic wait_hs(input int p, input int base);
    int n = 0;
    while (hs_cnt[p] == base && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs_timeout", {31'd0, n < 50}, 32'd1);
  endtask

  // Issue one op on port p, check latency and values, then stall the response for hold cycles.
  task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input int hold,
                        input logic [31:0] er, input logic ez);
    int base, hs, n;
    rsp_ready[p] = 1'b0;
    req_a[p] = a; req_b[p] = b; req_ctrl[p] = c;
    base = hs_cnt[p];
    req_valid[p] = 1'b1;
    wait_hs(p, base);
    req_valid[p] = 1'b0;
    hs = m_hs;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[p] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", cyc - hs, 32'd2);
    check("op_result", rsp_result[p], er);
    check("op_zero", {31'd0, rsp_zero[p]}, {31'd0, ez});
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid[p]}, 32'd1);
      check("hold_result", rsp_result[p], er);
      check("hold_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int base, n, start, seen0, seen1;
    logic [3:0] codes [6];
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
    codes[3] = 4'b0110; codes[4] = 4'b0111; codes[5] = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = '0; req_b[i] = '0; req_ctrl[i] = '0;
    end
    rst_n = 1'b0;
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    @(posedge clk); #1;
    check_reset("por");
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(0, 32'd5, 32'd7, 4'b0010, 0, 32'd12, 1'b0);
    run_op(1, 32'd9, 32'd9, 4'b0110, 0, 32'd0, 1'b1);
    run_op(1, 32'd3, 32'd8, 4'b0111, 0, 32'd1, 1'b0);

    // Stalled NOR response with req1 waiting: req1 must not be accepted until it drains.
    req_a[1] = 32'd1; req_b[1] = 32'd1; req_ctrl[1] = 4'b0010;
    base = hs_cnt[1];
    req_valid[1] = 1'b1;
    run_op(0, 32'd0, 32'd0, 4'b1100, 4, 32'hFFFF_FFFF, 1'b0);
    wait_hs(1, base);
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1 rsp_ready[1] = 1'b0;

    // Reset in EXEC: abort, then a held req0 is taken in the first IDLE cycle.
    req_a[0] = 32'd20; req_b[0] = 32'd22; req_ctrl[0] = 4'b0010;
    base = hs_cnt[0];
    req_valid[0] = 1'b1;
    wait_hs(0, base);
    req_a[0] = 32'd3; req_b[0] = 32'd4;
    #2 rst_n = 1'b0;
    #1 check_reset("exec_rst");
    @(posedge clk); #1;
    check_reset("exec_rst_hold");
    rst_n = 1'b1;
    #1 check("first_idle_ready0", {31'd0, req0_ready}, 32'd1);
    base = hs_cnt[0];
    wait_hs(0, base);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_result", rsp_result[0], 32'd7);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;

    // Both requesters continuously valid with ADD 1+1.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 32'd1; req_b[i] = 32'd1; req_ctrl[i] = 4'b0010;
    end
    rsp_ready = 2'b11;
    start = grant_log.size();
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() < start + 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 2'b00;
    check("grant_timeout", {31'd0, n < 60}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (start + i < grant_log.size())
        check("grant_seq", {31'd0, grant_log[start + i]}, RR_EN ? (i % 2) : 0);
    end
    repeat (5) @(posedge clk);
    #1 rsp_ready = 2'b00;

    // Randomized traffic with random response back-pressure.
    seen0 = hs_cnt[0];
    seen1 = hs_cnt[1];
    repeat (800) begin
      @(posedge clk); #1;
      if (hs_cnt[0] != seen0) begin seen0 = hs_cnt[0]; req_valid[0] = 1'b0; end
      if (hs_cnt[1] != seen1) begin seen1 = hs_cnt[1]; req_valid[1] = 1'b0; end
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
          req_a[p]    = $urandom();
          req_b[p]    = ($urandom_range(0, 3) == 0) ? req_a[p] : $urandom();
          req_ctrl[p] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                   : codes[$urandom_range(0, 5)];
          req_valid[p] = 1'b1;
        end
        rsp_ready[p] = 1'($urandom_range(0, 1));
      end
    end
    rsp_ready = 2'b11;
    n = 0;
    while ((req_valid != 2'b00 || m_busy) && n < 100) begin
      @(posedge clk); #1;
      if (hs_cnt[0] != seen0) begin seen0 = hs_cnt[0]; req_valid[0] = 1'b0; end
      if (hs_cnt[1] != seen1) begin seen1 = hs_cnt[1]; req_valid[1] = 1'b0; end
      n++;
    end
    check("drain_timeout", {31'd0, n < 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
